// File: rtl/contador_comparador_param.sv
// Modulo-MODULO up/down counter with clamped parallel load, saturating wrap counter and
// magnitude comparator against chaves. Define COMPARADOR_REGISTRADO_EN to register menor/maior/igual.
module contador_comparador_param #(
    parameter int N      = 4,
    parameter int MODULO = 16,
    parameter int V      = 4
) (
    input  logic         clock,
    input  logic         zera,
    input  logic         carrega,
    input  logic         conta,
    input  logic         sentido,
    input  logic [N-1:0] dados,
    input  logic [N-1:0] chaves,
    output logic [N-1:0] db_contagem,
    output logic         menor,
    output logic         maior,
    output logic         igual,
    output logic         fim,
    output logic         rco,
    output logic [V-1:0] voltas
);

    localparam logic [N-1:0] COUNT_MAX  = N'(MODULO - 1);
    localparam logic [N-1:0] COUNT_ZERO = N'(1'b0);
    localparam logic [N-1:0] COUNT_ONE  = N'(1'b1);
    localparam logic [V-1:0] VOLTAS_MAX = {V{1'b1}};
    localparam logic [V-1:0] VOLTAS_ONE = V'(1'b1);

    logic [N-1:0] count_r;
    logic [V-1:0] voltas_r;
    logic         fim_s;
    logic [N-1:0] dados_clamp_s;
    logic         menor_s;
    logic         maior_s;
    logic         igual_s;

    // Terminal value depends on the direction currently requested, not on conta.
    always_comb begin
        fim_s = 1'b0;
        if (sentido) begin
            fim_s = (count_r == COUNT_ZERO);
        end else begin
            fim_s = (count_r == COUNT_MAX);
        end
    end

    // Out-of-range load values are clamped to the top of the count range.
    always_comb begin
        dados_clamp_s = dados;
        if (dados > COUNT_MAX) begin
            dados_clamp_s = COUNT_MAX;
        end else begin
            dados_clamp_s = dados;
        end
    end

    // Counter and wrap counter state, priority zera > carrega > conta > hold.
    always_ff @(posedge clock) begin
        if (zera) begin
            count_r  <= COUNT_ZERO;
            voltas_r <= {V{1'b0}};
        end else if (carrega) begin
            count_r <= dados_clamp_s;
        end else if (conta) begin
            if (fim_s) begin
                count_r <= sentido ? COUNT_MAX : COUNT_ZERO;
                if (voltas_r != VOLTAS_MAX) begin
                    voltas_r <= voltas_r + VOLTAS_ONE;
                end
            end else if (sentido) begin
                count_r <= count_r - COUNT_ONE;
            end else begin
                count_r <= count_r + COUNT_ONE;
            end
        end
    end

`ifdef COMPARADOR_REGISTRADO_EN
    // Registered comparator: reflects count/chaves as seen at the previous edge.
    always_ff @(posedge clock) begin
        if (zera) begin
            menor_s <= 1'b0;
            maior_s <= 1'b0;
            igual_s <= 1'b1;
        end else begin
            menor_s <= (count_r < chaves);
            maior_s <= (count_r > chaves);
            igual_s <= (count_r == chaves);
        end
    end
`else
    // Combinational one-hot magnitude compare.
    always_comb begin
        menor_s = 1'b0;
        maior_s = 1'b0;
        igual_s = 1'b0;
        if (count_r < chaves) begin
            menor_s = 1'b1;
        end else if (count_r > chaves) begin
            maior_s = 1'b1;
        end else begin
            igual_s = 1'b1;
        end
    end
`endif

    assign db_contagem = count_r;
    assign voltas      = voltas_r;
    assign fim         = fim_s;
    assign rco         = fim_s & conta;
    assign menor       = menor_s;
    assign maior       = maior_s;
    assign igual       = igual_s;

endmodule

// File: tb/tb_contador_comparador_param.sv
// Scoreboard bench for contador_comparador_param (N=4, MODULO=10, V=2, combinational compare):
// driver pushes model expectations, monitor pops and compares DUT outputs.
module tb_contador_comparador_param;

    localparam int N      = 4;
    localparam int MODULO = 10;
    localparam int V      = 2;
    localparam int VMAX   = (1 << V) - 1;

    typedef struct {
        int cnt;
        int menor;
        int maior;
        int igual;
        int fim;
        int rco;
        int voltas;
    } exp_t;

    logic         clock = 1'b0;
    logic         zera = 1'b0, carrega = 1'b0, conta = 1'b0, sentido = 1'b0;
    logic [N-1:0] dados = 4'd0, chaves = 4'd0;
    logic [N-1:0] db_contagem;
    logic         menor, maior, igual, fim, rco;
    logic [V-1:0] voltas;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    int   m_volt = 0;
    bit   m_known = 1'b0;

    contador_comparador_param #(.N(N), .MODULO(MODULO), .V(V)) dut (
        .clock(clock), .zera(zera), .carrega(carrega), .conta(conta), .sentido(sentido),
        .dados(dados), .chaves(chaves), .db_contagem(db_contagem), .menor(menor),
        .maior(maior), .igual(igual), .fim(fim), .rco(rco), .voltas(voltas)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs, record expected outputs, then advance the model past the edge.
    task automatic step(input bit z, input bit ld, input bit en, input bit dir,
                        input int d, input int ch);
        exp_t e;
        bit   at_end;
        @(negedge clock);
        zera = z; carrega = ld; conta = en; sentido = dir;
        dados = N'(d); chaves = N'(ch);
        if (m_known) begin
            at_end   = dir ? (m_cnt == 0) : (m_cnt == MODULO - 1);
            e.cnt    = m_cnt;
            e.menor  = (m_cnt < ch) ? 1 : 0;
            e.maior  = (m_cnt > ch) ? 1 : 0;
            e.igual  = (m_cnt == ch) ? 1 : 0;
            e.fim    = at_end ? 1 : 0;
            e.rco    = (at_end && en) ? 1 : 0;
            e.voltas = m_volt;
            exp_q.push_back(e);
            if (z) begin
                m_cnt = 0; m_volt = 0;
            end else if (ld) begin
                m_cnt = (d > MODULO - 1) ? MODULO - 1 : d;
            end else if (en) begin
                if (at_end) m_volt = (m_volt < VMAX) ? m_volt + 1 : VMAX;
                m_cnt = dir ? (m_cnt + MODULO - 1) % MODULO : (m_cnt + 1) % MODULO;
            end
        end else if (z) begin
            m_cnt = 0; m_volt = 0; m_known = 1'b1;
        end
    endtask

    // Monitor: compare every pending expectation against DUT outputs mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("db_contagem", int'(db_contagem), e.cnt);
                check("menor", int'(menor), e.menor);
                check("maior", int'(maior), e.maior);
                check("igual", int'(igual), e.igual);
                check("fim", int'(fim), e.fim);
                check("rco", int'(rco), e.rco);
                check("voltas", int'(voltas), e.voltas);
                check("onehot", int'(menor) + int'(maior) + int'(igual), 1);
            end
        end
    end

    initial begin
        int r;
        // Reset, then reset-state compare with chaves 0 and 1
        step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        // Ten up-counting edges: 1..9, wrap to 0
        for (int i = 0; i < 11; i++) step(0, 0, 1, 0, 0, 5);
        // Load 0 then count down across the wrap
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 1, 0, 9);
        // Clamped load, then load with conta asserted
        step(0, 1, 0, 0, 12, 9);
        step(0, 1, 1, 0, 3, 3);
        step(0, 1, 0, 0, 15, 3);
        // Reach count 7 with extra wraps, compare, then reset with everything asserted
        step(0, 1, 0, 0, 7, 6);
        step(0, 0, 0, 0, 0, 6);
        step(0, 0, 0, 0, 0, 8);
        step(1, 1, 1, 0, 2, 8);
        step(0, 0, 0, 0, 0, 0);
        // Five wraps to saturate voltas
        for (int i = 0; i < 52; i++) step(0, 0, 1, 0, 0, i % 16);
        // Direction change at every edge
        for (int i = 0; i < 12; i++) step(0, 0, 1, i % 2, 0, 4);
        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            step((r < 4), (r >= 4 && r < 16), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 15));
        end
        @(negedge clock);
        #5;
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/contador_comparador_param.md
Name: contador_comparador_param

Overview:
Parametrised successor of the 4-bit counter/comparator datapath. It contains an N-bit modulo-MODULO up/down counter with synchronous clear, parallel load and count enable, and a magnitude comparator of the count against chaves. It adds direction control, terminal-count and carry outputs, and a saturating wrap counter (voltas). It is the datapath block driven by the game/sequence control units of later experiments.

Parameters:
N, 4, width of count, dados and chaves.
MODULO, 16, count range 0..MODULO-1; legal range 2..2^N.
V, 4, width of the voltas wrap counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
zera  input  1  synchronous active-high reset/clear.
carrega  input  1  synchronous parallel load of dados.
conta  input  1  count enable.
sentido  input  1  count direction: 0 = up, 1 = down.
dados  input  N  parallel load value.
chaves  input  N  comparison operand.
db_contagem  output  N  current count.
menor  output  1  count < chaves (unsigned).
maior  output  1  count > chaves (unsigned).
igual  output  1  count == chaves.
fim  output  1  count is at the terminal value for the current sentido.
rco  output  1  fim & conta: the count wraps on the next edge.
voltas  output  V  number of wraps since the last clear, saturating.

Behaviour:
- Priority on each rising edge: zera > carrega > conta > hold.
- zera=1: count <= 0 and voltas <= 0. This applies mid-count and regardless of the other inputs.
- carrega=1 (zera=0): count <= dados if dados <= MODULO-1, else MODULO-1 (clamp).
  - voltas is unchanged.
  - conta is ignored in that cycle.
- conta=1 with sentido=0: count <= count+1; at MODULO-1 it wraps to 0.
- conta=1 with sentido=1: count <= count-1; at 0 it wraps to MODULO-1.
- Hold: conta=0 and no zera/carrega leaves the count unchanged.
- Terminal value and outputs:
  - fim is combinational: (sentido=0 & count==MODULO-1) | (sentido=1 & count==0).
  - fim is independent of conta.
  - rco = fim & conta.
- Wrap counting:
  - A wrap is an edge with zera=0, carrega=0, conta=1 and fim=1.
  - On a wrap, voltas <= voltas+1 if voltas < 2^V-1; otherwise it holds (saturates).
- Comparator:
  - Unsigned N-bit compare.
  - Exactly one of menor/maior/igual is high at all times.
  - In the default build these outputs are combinational from the count and chaves, with 0-cycle latency.
- Reset values: db_contagem=0, voltas=0, fim=(sentido==1), rco=fim&conta.
  - Comparator after reset: igual=1 if chaves==0, else menor=1.
- Direction change takes effect on the next counting edge. There is no extra cycle.
- N=4, MODULO=16 with sentido=0 reproduces the previous-generation 4-bit counter behaviour.

Optional Feature:
COMPARADOR_REGISTRADO_EN:
- Defined: menor/maior/igual are registered. They reflect count/chaves as sampled at the previous rising edge (1-cycle latency).
  - Registered reset value is menor=0, maior=0, igual=1 (treated as 0 vs 0).
  - Reset is applied on zera.
- Undefined: the comparator is purely combinational as described above.
- fim and rco are combinational in both builds.

Test Plan:
1. Reset/compare: zera=1 for 1 edge with chaves=0 -> db_contagem=0, igual=1, fim=0, voltas=0. Then set chaves=1 -> menor=1.
2. Up count and wrap (N=4, MODULO=10): conta=1, sentido=0, 10 edges -> count sequence 1..9,0. At count 9: fim=1, rco=1. After the wrap: voltas=1.
3. Down count: load dados=0, then sentido=1, conta=1, 1 edge -> count=MODULO-1, voltas incremented. With count=0 before that edge, fim=1.
4. Load and clamp (MODULO=10): carrega=1, dados=4'b1100 -> count=9. Then carrega=1 and conta=1 together with dados=3 -> count=3, no increment.
5. Priority/mid-operation reset: zera=1, carrega=1, conta=1 at count=7 with voltas=2 -> count=0, voltas=0. Also chaves=6 at count=7 -> maior=1; chaves=8 -> menor=1.
6. Saturation and registered compare: V=2, force 5 wraps -> voltas stays 3. With COMPARADOR_REGISTRADO_EN, igual rises one edge after count reaches chaves.
